cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
Bridges the L2-side cache (256-bit line interface) to the off-chip burst memory (4 x 64-bit bursts per transaction).
- Sits directly upstream of the parameterized burst memory model in the mp4 top.
- Serializes cache writebacks into bursts and assembles fill bursts into a full line.
- Returns a single-cycle completion pulse to the cache.

Parameters:
BURST_WIDTH, 64, bits per memory burst
BURSTS, 4, bursts per cache line
ADDR_WIDTH, 32, address width
LINE_WIDTH, BURST_WIDTH*BURSTS (256), derived; do not override

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
line_i  in  LINE_WIDTH  writeback line from cache
line_o  out  LINE_WIDTH  assembled fill line to cache
address_i  in  ADDR_WIDTH  cache request address
read_i  in  1  cache line-read request
write_i  in  1  cache line-write request
resp_o  out  1  transaction complete, one-cycle pulse
burst_i  in  BURST_WIDTH  read burst from memory
burst_o  out  BURST_WIDTH  write burst to memory
address_o  out  ADDR_WIDTH  line-aligned memory address
read_o  out  1  memory read request
write_o  out  1  memory write request
resp_i  in  1  memory burst valid/accepted

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, all outputs 0 (line_o, burst_o, address_o, read_o, write_o, resp_o).
- Reset asserted mid-transaction: abort immediately; read_o/write_o drop the same instant; no resp_o is generated.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: requests are sampled only in this state.
  - write_i=1 -> latch line_i and address_i, then go to WRITE. Write wins if read_i=1 in the same cycle.
  - else read_i=1 -> latch address_i, then go to READ.
- address_o = {addr_reg[ADDR_WIDTH-1:5], 5'b0}. It is held constant while in READ/WRITE and is 0 in IDLE.
- READ:
  - read_o=1 for the whole state.
  - Each cycle with resp_i=1: line_o[count*64 +: 64] <= burst_i and count++.
  - When the 4th burst is captured (count==3 && resp_i), go to DONE.
  - Cycles with resp_i=0 are stalls; count holds.
- WRITE:
  - write_o=1 for the whole state; burst_o = line_reg[count*64 +: 64].
  - count advances on resp_i; after the 4th accepted burst, go to DONE.
- Burst order: burst 0 = line bits [63:0], first on the bus (little-endian).
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0; count resets to 0; next state IDLE.
  - line_o stays stable from DONE until the next READ overwrites it.
- Cache contract: hold read_i/write_i until resp_o, and deassert them in the cycle after resp_o. A request still high in IDLE starts a new transaction.
- Minimum latency: request accepted in cycle 0, bursts in cycles 1–4 (back-to-back resp_i), resp_o in cycle 5.
- resp_i outside READ/WRITE is ignored.
- line_i is registered at accept, so the cache may change line_i during WRITE.

Optional Feature:
CACHELINE_ADAPTOR_PROTO_CHECK_EN
- Defined: adds output err_o (1 bit, reset 0) and concurrent assertions.
  - err_o is sticky-set on any of: resp_i=1 in IDLE or DONE; read_i&write_i in IDLE; request dropped before resp_o while in READ/WRITE.
  - err_o clears only on reset.
  - Assertions report the violation via $error.
- Undefined: no err_o port, no checker logic; behaviour is otherwise identical.

Decomposition:
- Package cacheline_adaptor_pkg holds:
  - state enum (IDLE, READ, WRITE, DONE);
  - derived constants LINE_WIDTH and OFFSET_BITS (=$clog2(LINE_WIDTH/8)=5);
  - count width ($clog2(BURSTS)).
- No sub-module. An optional burst_shift_reg sub-module (line register with indexed burst load/select) is acceptable but not required.

Test Plan:
- Reset: hold rst=0 for 5 cycles with read_i=1 -> all outputs 0 and no read_o.
- Read fill: read_i=1, address_i=0x0000_1234. Memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back.
  -> address_o=0x0000_1220 and read_o high 4 cycles.
  -> line_o={0x44..,0x33..,0x22..,0x11..}.
  -> resp_o pulses in cycle 5.
- Writeback with stalls: write_i=1, line_i=256'h(DDDD..|CCCC..|BBBB..|AAAA..), resp_i pattern 1,0,1,0,0,1,1.
  -> burst_o presents AAAA, BBBB, CCCC, DDDD in order, each held until accepted.
  -> resp_o pulses once, the cycle after the last resp_i.
- Simultaneous request: read_i=write_i=1 in IDLE -> WRITE taken (write_o=1, read_o=0).
  -> with PROTO_CHECK_EN defined, err_o=1.
- Mid-transaction reset: assert rst=0 after 2 read bursts -> read_o drops asynchronously.
  -> after release, a fresh read to 0x40 completes with line_o fully replaced.
- Back-to-back: after resp_o, assert write_i to 0x80 in the next cycle -> a new WRITE starts from IDLE with no lost or duplicated bursts.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared types and derived constants for the
// cache-line to burst-memory adaptor.
package cacheline_adaptor_pkg;

  localparam int DEF_BURST_WIDTH = 64;
  localparam int DEF_BURSTS      = 4;
  localparam int DEF_ADDR_WIDTH  = 32;

  localparam int LINE_WIDTH  = DEF_BURST_WIDTH * DEF_BURSTS;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W       = $clog2(DEF_BURSTS);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if: cache-side line port plus memory-side burst port.
// err_o exists only with CACHELINE_ADAPTOR_PROTO_CHECK_EN.
interface cacheline_adaptor_if
  import cacheline_adaptor_pkg::*;
#(
  parameter int BURST_WIDTH = DEF_BURST_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH  = BURST_WIDTH * DEF_BURSTS
);

  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;
`ifdef CACHELINE_ADAPTOR_PROTO_CHECK_EN
  logic                   err_o;

  modport slave (
    input  line_i, address_i, read_i,
    input  write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o,
    output address_o, read_o, write_o,
    output err_o
  );

  modport master (
    output line_i, address_i, read_i,
    output write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o,
    input  address_o, read_o, write_o,
    input  err_o
  );
`else
  modport slave (
    input  line_i, address_i, read_i,
    input  write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o,
    output address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i,
    output write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o,
    input  address_o, read_o, write_o
  );
`endif

endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: serializes line writebacks / assembles line fills.
// Define CACHELINE_ADAPTOR_PROTO_CHECK_EN for err_o and protocol asserts.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int BURST_WIDTH = DEF_BURST_WIDTH,
  parameter int BURSTS      = DEF_BURSTS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input logic                clk,
  input logic                rst,
  cacheline_adaptor_if.slave bus
);

  localparam int LW  = BURST_WIDTH * BURSTS;
  localparam int OFF = $clog2(LW / 8);
  localparam int CW  = cnt_width(BURSTS);

  localparam logic [CW-1:0] LAST = CW'(BURSTS - 1);

  state_t         state;
  logic [CW-1:0]  count;
  logic [CW-1:0]  nxt;
  logic [LW-1:0]  line_reg;
  logic           last;

  logic [ADDR_WIDTH-1:0] aligned;

  always_comb begin
    nxt     = count + 1'b1;
    last    = (count == LAST);
    aligned = {bus.address_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      count         <= '0;
      line_reg      <= '0;
      bus.line_o    <= '0;
      bus.burst_o   <= '0;
      bus.address_o <= '0;
      bus.read_o    <= 1'b0;
      bus.write_o   <= 1'b0;
      bus.resp_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          count <= '0;
          // write wins a simultaneous request
          if (bus.write_i) begin
            state         <= WRITE;
            line_reg      <= bus.line_i;
            bus.burst_o   <= bus.line_i[BURST_WIDTH-1:0];
            bus.address_o <= aligned;
            bus.write_o   <= 1'b1;
          end else if (bus.read_i) begin
            state         <= READ;
            bus.address_o <= aligned;
            bus.read_o    <= 1'b1;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            bus.line_o[count*BURST_WIDTH +: BURST_WIDTH]
              <= bus.burst_i;
            count <= nxt;
            if (last) begin
              state      <= DONE;
              bus.read_o <= 1'b0;
              bus.resp_o <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            count <= nxt;
            if (last) begin
              state       <= DONE;
              bus.write_o <= 1'b0;
              bus.resp_o  <= 1'b1;
              bus.burst_o <= '0;
            end else begin
              bus.burst_o
                <= line_reg[nxt*BURST_WIDTH +: BURST_WIDTH];
            end
          end
        end
        DONE: begin
          state         <= IDLE;
          count         <= '0;
          bus.resp_o    <= 1'b0;
          bus.address_o <= '0;
        end
      endcase
    end
  end

`ifdef CACHELINE_ADAPTOR_PROTO_CHECK_EN
  logic viol;

  always_comb begin
    viol = 1'b0;
    unique case (1'b1)
      state == IDLE:
        viol = bus.resp_i | (bus.read_i & bus.write_i);
      state == READ:  viol = ~bus.read_i;
      state == WRITE: viol = ~bus.write_i;
      state == DONE:  viol = bus.resp_i;
      default:        viol = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.err_o <= 1'b0;
    else      bus.err_o <= bus.err_o | viol;
  end

  a_resp_idle : assert property (
    @(posedge clk) disable iff (!rst)
    !((state == IDLE || state == DONE) && bus.resp_i)
  ) else $error("resp_i outside a transfer");

  a_both_req : assert property (
    @(posedge clk) disable iff (!rst)
    !(state == IDLE && bus.read_i && bus.write_i)
  ) else $error("read_i and write_i together");

  a_rd_hold : assert property (
    @(posedge clk) disable iff (!rst)
    !(state == READ && !bus.read_i)
  ) else $error("read_i dropped before resp_o");

  a_wr_hold : assert property (
    @(posedge clk) disable iff (!rst)
    !(state == WRITE && !bus.write_i)
  ) else $error("write_i dropped before resp_o");
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed table, corner sequences and random
// transactions checked against a transaction-level model.
module tb_cacheline_adaptor;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  logic [255:0] exp_lo;

  always #5 clk = ~clk;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [31:0]  exp_addr;
    logic [255:0] line;
    bit [31:0]    pat;
    int           plen;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One cache transaction. For reads, line is the data memory returns;
  // for writes, it is the line the cache hands over.
  task automatic do_txn(input bit wr, input bit both,
                        input logic [31:0] addr,
                        input logic [255:0] line,
                        input logic [31:0] exp_addr,
                        input bit [31:0] pat, input int plen,
                        input int stall_pct, input int lat,
                        input bit chain, input string nm);
    logic [63:0] bursts [$];
    int k, cyc, waited;
    bit r;
    for (int i = 0; i < 4; i++) bursts.push_back(line[i*64 +: 64]);
    bus.address_i = addr;
    bus.line_i    = line;
    bus.write_i   = wr;
    bus.read_i    = !wr || both;
    bus.resp_i    = 1'b0;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!(bus.read_o || bus.write_o) && waited < 4);
    chk({nm, "_accept_lat"}, waited, lat);
    if (wr) bus.line_i = rand_line();
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 200) begin
      chk({nm, "_read_o"}, bus.read_o, !wr);
      chk({nm, "_write_o"}, bus.write_o, wr);
      chk({nm, "_address_o"}, bus.address_o, exp_addr);
      chk({nm, "_resp_early"}, bus.resp_o, 1'b0);
      if (wr) chk({nm, "_burst_o"}, bus.burst_o, bursts[k]);
      r = (cyc < plen) ? pat[cyc]
                       : ($urandom_range(99) >= stall_pct);
      bus.resp_i  = r;
      bus.burst_i = r ? bursts[k] : {$urandom, $urandom};
      @(posedge clk); #1;
      if (r) k++;
      cyc++;
    end
    bus.resp_i = 1'b0;
    if (k < 4) chk({nm, "_timeout"}, k, 4);
    chk({nm, "_resp_o"}, bus.resp_o, 1'b1);
    chk({nm, "_done_rd"}, bus.read_o, 1'b0);
    chk({nm, "_done_wr"}, bus.write_o, 1'b0);
    if (!wr) begin
      exp_lo = {bursts[3], bursts[2], bursts[1], bursts[0]};
    end
    chk({nm, "_line_o"}, bus.line_o, exp_lo);
    if (!chain) begin
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      @(posedge clk); #1;
      chk({nm, "_resp_pulse"}, bus.resp_o, 1'b0);
      chk({nm, "_idle_addr"}, bus.address_o, 32'h0);
      chk({nm, "_line_hold"}, bus.line_o, exp_lo);
    end
  endtask

  initial begin
    vec_t vt [5];
    logic [31:0] a;

    vt[0] = '{0, 32'h0000_1234, 32'h0000_1220,
              {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
              32'b1111, 4};
    vt[1] = '{1, 32'h0000_5678, 32'h0000_5660,
              {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}},
              32'b1100101, 7};
    vt[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
              {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'h0F0F_0F0F_F0F0_F0F0, 64'h5555_AAAA_3333_CCCC},
              32'b0, 0};
    vt[3] = '{1, 32'h0000_003F, 32'h0000_0020,
              {64'hCAFE_0003, 64'hCAFE_0002,
               64'hCAFE_0001, 64'hCAFE_0000},
              32'b0, 0};
    vt[4] = '{0, 32'h0000_0040, 32'h0000_0040,
              {64'h4, 64'h3, 64'h2, 64'h1},
              32'b10101010, 8};

    rst          = 1'b1;
    bus.line_i   = '0;
    bus.address_i = '0;
    bus.read_i   = 1'b0;
    bus.write_i  = 1'b0;
    bus.burst_i  = '0;
    bus.resp_i   = 1'b0;
    exp_lo       = '0;
    #1 rst = 1'b0;

    // reset held with a pending read
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_1234;
    for (int i = 0; i < 5; i++) begin
      bus.resp_i = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_read_o", bus.read_o, 1'b0);
      chk("rst_write_o", bus.write_o, 1'b0);
      chk("rst_resp_o", bus.resp_o, 1'b0);
      chk("rst_address_o", bus.address_o, 32'h0);
      chk("rst_burst_o", bus.burst_o, 64'h0);
      chk("rst_line_o", bus.line_o, 256'h0);
    end
    bus.read_i = 1'b0;
    bus.resp_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      do_txn(vt[i].wr, 1'b0, vt[i].addr, vt[i].line,
             vt[i].exp_addr, vt[i].pat, vt[i].plen,
             30, 1, 1'b0, $sformatf("vec%0d", i));
    end

    // memory responses while idle must be ignored
    for (int i = 0; i < 4; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("idle_resp_rd", bus.read_o, 1'b0);
      chk("idle_resp_wr", bus.write_o, 1'b0);
      chk("idle_resp_resp", bus.resp_o, 1'b0);
      chk("idle_resp_line", bus.line_o, exp_lo);
    end
    bus.resp_i = 1'b0;

    // simultaneous read and write: write wins
    do_txn(1'b1, 1'b1, 32'h0000_0A10, rand_line(),
           32'h0000_0A00, 32'b0, 0, 20, 1, 1'b0, "both");
`ifdef CACHELINE_ADAPTOR_PROTO_CHECK_EN
    chk("both_err_o", bus.err_o, 1'b1);
`endif

    // reset mid-read after two bursts
    bus.address_i = 32'h0000_0100;
    bus.read_i    = 1'b1;
    @(posedge clk); #1;
    chk("mrst_read_o", bus.read_o, 1'b1);
    for (int i = 0; i < 2; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    bus.resp_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mrst_read_drop", bus.read_o, 1'b0);
    chk("mrst_resp_o", bus.resp_o, 1'b0);
    chk("mrst_line_o", bus.line_o, 256'h0);
    chk("mrst_address_o", bus.address_o, 32'h0);
    bus.read_i = 1'b0;
    exp_lo = '0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("mrst_no_resp", bus.resp_o, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    do_txn(1'b0, 1'b0, 32'h0000_0040, rand_line(),
           32'h0000_0040, 32'b0, 0, 30, 1, 1'b0, "mrst_fill");

    // back-to-back: write raised in the cycle after resp_o
    do_txn(1'b0, 1'b0, 32'h0000_0300, rand_line(),
           32'h0000_0300, 32'b1111, 4, 0, 1, 1'b1, "b2b_rd");
    do_txn(1'b1, 1'b0, 32'h0000_0080, rand_line(),
           32'h0000_0080, 32'b1111, 4, 0, 2, 1'b0, "b2b_wr");

    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      do_txn(1'($urandom), 1'b0, a, rand_line(),
             a & 32'hFFFF_FFE0, 32'b0, 0, 40, 1, 1'b0,
             $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
